// File: rtl/i2c_init_pkg.sv
// i2c_init_pkg: shared state encoding, table layout and constants
// for the I2C peripheral init sequencer.
package i2c_init_pkg;

   localparam int ENTRY_W     = 16;
   localparam int REG_MSB     = 15;
   localparam int REG_LSB     = 8;
   localparam int DATA_MSB    = 7;
   localparam int DATA_LSB    = 0;
   localparam int MAX_ENTRIES = 256;
   localparam int TABLE_W     = MAX_ENTRIES * ENTRY_W;

   localparam logic [7:0] FAIL_TIMEOUT = 8'hFF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_REQ,
      S_RST_FALL,
      S_RST_RISE,
      S_LOAD,
      S_ISSUE,
      S_WAIT_RSP,
      S_DONE,
      S_ERROR
   } state_e;

   function automatic logic [7:0] entry_reg(
      input logic [ENTRY_W-1:0] e
   );
      return e[REG_MSB:REG_LSB];
   endfunction

   function automatic logic [7:0] entry_data(
      input logic [ENTRY_W-1:0] e
   );
      return e[DATA_MSB:DATA_LSB];
   endfunction

endpackage

// File: rtl/i2c_init_if.sv
// i2c_init_if: write-command / response port between the init
// sequencer (master) and the I2C master controller (slave).
interface i2c_init_if;

   logic       cmd_valid_o;
   logic       cmd_ready_i;
   logic [6:0] cmd_dev_o;
   logic [7:0] cmd_reg_o;
   logic [7:0] cmd_data_o;
   logic       rsp_valid_i;
   logic       rsp_nack_i;

   modport master (
      output cmd_valid_o,
      output cmd_dev_o,
      output cmd_reg_o,
      output cmd_data_o,
      input  cmd_ready_i,
      input  rsp_valid_i,
      input  rsp_nack_i
   );

   modport slave (
      input  cmd_valid_o,
      input  cmd_dev_o,
      input  cmd_reg_o,
      input  cmd_data_o,
      output cmd_ready_i,
      output rsp_valid_i,
      output rsp_nack_i
   );

endinterface

// File: rtl/i2c_init_rom.sv
// i2c_init_rom: register-write table, one-cycle read latency,
// output cleared by reset and held between reads.
module i2c_init_rom
   import i2c_init_pkg::*;
#(
   parameter int unsigned        NUM_WRITES = 8,
   parameter logic [TABLE_W-1:0] TABLE      = '0
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               rd_en_i,
   input  logic [7:0]         addr_i,
   output logic [ENTRY_W-1:0] data_o
);

   localparam logic [8:0] DEPTH = 9'(NUM_WRITES);

   logic [ENTRY_W-1:0] data_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         data_q <= '0;
      end else if (rd_en_i) begin
         if ({1'b0, addr_i} < DEPTH) begin
            data_q <= TABLE[{addr_i, 4'h0} +: ENTRY_W];
         end else begin
            data_q <= '0;
         end
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: pulses the peripheral reset, waits for ready,
// then streams the init table to the I2C master with NACK retry.
module i2c_init_sequencer
   import i2c_init_pkg::*;
#(
   parameter int unsigned        NUM_WRITES    = 8,
   parameter logic [6:0]         DEV_ADDR      = 7'h60,
   parameter int unsigned        MAX_RETRIES   = 3,
   parameter int unsigned        RESET_TIMEOUT = 1000,
   parameter logic [TABLE_W-1:0] TABLE         = '0
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       start_i,
   output logic       prst_request_o,
   input  logic       prst_ready_i,
   i2c_init_if.master cmd,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic [7:0] fail_index_o
);

   localparam logic [31:0] TIMEOUT = 32'(RESET_TIMEOUT);
   localparam logic [7:0]  MAXR    = 8'(MAX_RETRIES);
   localparam logic [7:0]  LAST    = 8'(NUM_WRITES - 1);

   state_e             state_q;
   logic               prst_q;
   logic               valid_q;
   logic               busy_q;
   logic               done_q;
   logic               error_q;
   logic [7:0]         fail_q;
   logic [7:0]         idx_q;
   logic [7:0]         idx_d;
   logic [7:0]         retry_q;
   logic [31:0]        timer_q;
   logic [31:0]        timer_d;
   logic               rd_en;
   logic [ENTRY_W-1:0] rom_q;

   assign timer_d = (timer_q == '1) ? timer_q : timer_q + 32'd1;
   assign idx_d   = idx_q + 8'd1;
   assign rd_en   = (state_q == S_LOAD);

   i2c_init_rom #(
      .NUM_WRITES (NUM_WRITES),
      .TABLE      (TABLE)
   ) u_rom (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .rd_en_i (rd_en),
      .addr_i  (idx_q),
      .data_o  (rom_q)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         prst_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         fail_q  <= '0;
         idx_q   <= '0;
         retry_q <= '0;
         timer_q <= '0;
      end else begin
         prst_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  state_q <= S_RST_REQ;
                  prst_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  fail_q  <= '0;
                  idx_q   <= '0;
               end
            end
            S_RST_REQ: begin
               timer_q <= '0;
               state_q <= S_RST_FALL;
            end
            // ready may linger high right after the request
            S_RST_FALL: begin
               if (!prst_ready_i) begin
                  timer_q <= '0;
                  state_q <= S_RST_RISE;
               end else if (timer_d >= TIMEOUT) begin
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  fail_q  <= FAIL_TIMEOUT;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_RST_RISE: begin
               if (prst_ready_i) begin
                  if (NUM_WRITES == 0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     retry_q <= '0;
                     state_q <= S_LOAD;
                  end
               end else if (timer_d >= TIMEOUT) begin
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  fail_q  <= FAIL_TIMEOUT;
               end else begin
                  timer_q <= timer_d;
               end
            end
            S_LOAD: begin
               valid_q <= 1'b1;
               state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               if (cmd.cmd_ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= S_WAIT_RSP;
               end
            end
            S_WAIT_RSP: begin
               if (cmd.rsp_valid_i) begin
                  if (!cmd.rsp_nack_i) begin
                     if (idx_q == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        idx_q   <= idx_d;
                        retry_q <= '0;
                        state_q <= S_LOAD;
                     end
                  end else if (retry_q < MAXR) begin
                     retry_q <= retry_q + 8'd1;
                     valid_q <= 1'b1;
                     state_q <= S_ISSUE;
                  end else begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                     fail_q  <= idx_q;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign prst_request_o  = prst_q;
   assign cmd.cmd_valid_o = valid_q;
   assign cmd.cmd_dev_o   = DEV_ADDR;
   assign cmd.cmd_reg_o   = entry_reg(rom_q);
   assign cmd.cmd_data_o  = entry_data(rom_q);
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign error_o         = error_q;
   assign fail_index_o    = fail_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: scoreboard bench with a table-level model of
// the bring-up flow, random master latency, backpressure and NACKs.
`timescale 1ns/1ps
module tb_i2c_init_sequencer;
   import i2c_init_pkg::*;

   localparam int         NW   = 3;
   localparam int         MAXR = 3;
   localparam logic [6:0] DEV  = 7'h60;
   localparam logic [TABLE_W-1:0] TBL =
      TABLE_W'({16'hC35A, 16'h2B17, 16'h0180});

   logic [15:0] ref_tbl [NW] = '{16'h0180, 16'h2B17, 16'hC35A};

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, prst_a, rdy_a, busy_a, done_a, err_a;
   logic [7:0] fail_a;
   logic       start_b, prst_b, rdy_b, busy_b, done_b, err_b;
   logic [7:0] fail_b;

   i2c_init_if ifa ();
   i2c_init_if ifb ();

   i2c_init_sequencer #(
      .NUM_WRITES    (NW),
      .DEV_ADDR      (DEV),
      .MAX_RETRIES   (MAXR),
      .RESET_TIMEOUT (200),
      .TABLE         (TBL)
   ) dut_a (
      .clock_i        (clk),
      .reset_i        (rst),
      .start_i        (start_a),
      .prst_request_o (prst_a),
      .prst_ready_i   (rdy_a),
      .cmd            (ifa.master),
      .busy_o         (busy_a),
      .done_o         (done_a),
      .error_o        (err_a),
      .fail_index_o   (fail_a)
   );

   i2c_init_sequencer #(
      .NUM_WRITES    (0),
      .DEV_ADDR      (DEV),
      .MAX_RETRIES   (MAXR),
      .RESET_TIMEOUT (20),
      .TABLE         (TBL)
   ) dut_b (
      .clock_i        (clk),
      .reset_i        (rst),
      .start_i        (start_b),
      .prst_request_o (prst_b),
      .prst_ready_i   (rdy_b),
      .cmd            (ifb.master),
      .busy_o         (busy_b),
      .done_o         (done_b),
      .error_o        (err_b),
      .fail_index_o   (fail_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_rsp_cyc = 0;
   int hs_cnt = 0;
   int prst_cnt = 0;
   int vcnt_b = 0;
   int bp_req = 0;
   bit rand_ready = 0;
   int lat_lo = 5;
   int lat_hi = 5;
   int rise_a = 100;
   bit stuck_b = 0;

   logic [15:0] exp_q[$];
   bit          nack_plan[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: expected command stream and outcome from the
   // per-entry NACK counts.
   task automatic plan(input int n0, input int n1, input int n2,
                       output bit eerr, output logic [7:0] eidx);
      int nk[NW];
      nk = '{n0, n1, n2};
      eerr = 0;
      eidx = '0;
      exp_q.delete();
      nack_plan.delete();
      for (int e = 0; e < NW && !eerr; e++) begin
         int issues;
         issues = (nk[e] > MAXR) ? MAXR + 1 : nk[e] + 1;
         for (int t = 0; t < issues; t++) begin
            exp_q.push_back(ref_tbl[e]);
            nack_plan.push_back(t < nk[e]);
         end
         if (nk[e] > MAXR) begin
            eerr = 1;
            eidx = 8'(e);
         end
      end
   endtask

   // Peripheral reset controller models
   initial begin
      rdy_a = 1'b1;
      forever begin
         @(negedge clk);
         if (prst_a) begin
            repeat (2) @(posedge clk);
            #1 rdy_a = 1'b0;
            repeat (rise_a) @(posedge clk);
            #1 rdy_a = 1'b1;
         end
      end
   end

   initial begin
      rdy_b = 1'b1;
      forever begin
         @(negedge clk);
         if (prst_b && !stuck_b) begin
            repeat (2) @(posedge clk);
            #1 rdy_b = 1'b0;
            repeat (10) @(posedge clk);
            #1 rdy_b = 1'b1;
         end
      end
   end

   // Master model: ready generation and delayed responses
   initial begin
      ifa.cmd_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ifa.cmd_valid_o && bp_req > 0) begin
            ifa.cmd_ready_i = 1'b0;
            bp_req--;
         end else begin
            ifa.cmd_ready_i = rand_ready ?
               ($urandom_range(0, 2) != 0) : 1'b1;
         end
      end
   end

   initial begin
      bit n;
      int lat;
      ifa.rsp_valid_i = 1'b0;
      ifa.rsp_nack_i  = 1'b0;
      forever begin
         @(negedge clk);
         if (ifa.cmd_valid_o && ifa.cmd_ready_i) begin
            n = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
            lat = $urandom_range(lat_lo, lat_hi);
            repeat (lat) @(posedge clk);
            #1;
            ifa.rsp_valid_i = 1'b1;
            ifa.rsp_nack_i  = n;
            @(posedge clk);
            #1;
            ifa.rsp_valid_i = 1'b0;
            ifa.rsp_nack_i  = 1'b0;
         end
      end
   end

   initial begin
      ifb.cmd_ready_i = 1'b1;
      ifb.rsp_valid_i = 1'b0;
      ifb.rsp_nack_i  = 1'b0;
   end

   // Monitor: scoreboard pop on handshake, stall stability
   initial begin
      bit          stall;
      logic [15:0] stall_pl;
      logic [15:0] e;
      stall = 0;
      stall_pl = '0;
      forever begin
         @(negedge clk);
         if (prst_a) prst_cnt++;
         if (ifb.cmd_valid_o) vcnt_b++;
         if (ifa.rsp_valid_i) last_rsp_cyc = cyc;
         if (rst) begin
            stall = 0;
         end else begin
            if (stall) begin
               chk("stall_valid", 32'(ifa.cmd_valid_o), 32'd1);
               chk("stall_payload",
                   32'({ifa.cmd_reg_o, ifa.cmd_data_o}), 32'(stall_pl));
            end
            if (ifa.cmd_valid_o && ifa.cmd_ready_i) begin
               hs_cnt++;
               chk("cmd_expected", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("cmd_reg", 32'(ifa.cmd_reg_o), 32'(e[15:8]));
                  chk("cmd_data", 32'(ifa.cmd_data_o), 32'(e[7:0]));
               end
               chk("cmd_dev", 32'(ifa.cmd_dev_o), 32'(DEV));
            end
            stall = ifa.cmd_valid_o && !ifa.cmd_ready_i;
            stall_pl = {ifa.cmd_reg_o, ifa.cmd_data_o};
         end
      end
   end

   task automatic run_a(input int n0, input int n1, input int n2,
                        input bit bp, input int hold);
      bit         eerr;
      logic [7:0] eidx;
      int         p0;
      bit         fin;
      plan(n0, n1, n2, eerr, eidx);
      bp_req = bp ? 7 : 0;
      p0 = prst_cnt;
      @(posedge clk);
      #1 start_a = 1'b1;
      @(negedge clk);
      chk("req_not_early", 32'(prst_a), 32'd0);
      @(posedge clk);
      #1;
      if (hold == 0) start_a = 1'b0;
      @(negedge clk);
      chk("req_pulse", 32'(prst_a), 32'd1);
      chk("busy_on_start", 32'(busy_a), 32'd1);
      @(negedge clk);
      chk("req_one_cycle", 32'(prst_a), 32'd0);
      repeat (hold) @(negedge clk);
      start_a = 1'b0;
      fin = 0;
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge clk);
         fin = done_a | err_a;
      end
      chk("seq_finished", 32'(fin), 32'd1);
      chk("end_latency", 32'(cyc - last_rsp_cyc), 32'd1);
      chk("done", 32'(done_a), 32'(!eerr));
      chk("error", 32'(err_a), 32'(eerr));
      chk("fail_index", 32'(fail_a), eerr ? 32'(eidx) : 32'd0);
      chk("busy_end", 32'(busy_a), 32'd0);
      chk("cmds_left", 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge clk);
      chk("prst_pulses", 32'(prst_cnt - p0), 32'd1);
   endtask

   task automatic reset_mid();
      bit         eerr;
      logic [7:0] eidx;
      int         h0;
      bit         seen;
      plan(0, 0, 0, eerr, eidx);
      lat_lo = 5;
      lat_hi = 5;
      h0 = hs_cnt;
      @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      seen = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         seen = (hs_cnt >= h0 + 2);
      end
      chk("reach_wait_rsp", 32'(seen), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_valid", 32'(ifa.cmd_valid_o), 32'd0);
      chk("rst_prst", 32'(prst_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_error", 32'(err_a), 32'd0);
      chk("rst_fail", 32'(fail_a), 32'd0);
      chk("rst_payload",
          32'({ifa.cmd_reg_o, ifa.cmd_data_o}), 32'd0);
      chk("rst_dev", 32'(ifa.cmd_dev_o), 32'(DEV));
      repeat (12) @(negedge clk);
      chk("late_rsp_busy", 32'(busy_a), 32'd0);
      chk("late_rsp_valid", 32'(ifa.cmd_valid_o), 32'd0);
      chk("late_rsp_done", 32'(done_a), 32'd0);
      exp_q.delete();
      nack_plan.delete();
   endtask

   task automatic run_b(input bit stuck);
      int v0;
      bit fin;
      bit seen_low;
      bit rose;
      stuck_b = stuck;
      v0 = vcnt_b;
      @(posedge clk);
      #1 start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      if (stuck) begin
         fin = 0;
         for (int i = 0; i < 500 && !fin; i++) begin
            @(negedge clk);
            fin = err_b | done_b;
         end
         chk("to_finished", 32'(fin), 32'd1);
         chk("to_error", 32'(err_b), 32'd1);
         chk("to_done", 32'(done_b), 32'd0);
         chk("to_fail_index", 32'(fail_b), 32'hFF);
         chk("to_busy", 32'(busy_b), 32'd0);
      end else begin
         seen_low = 0;
         rose = 0;
         for (int i = 0; i < 300 && !rose; i++) begin
            @(negedge clk);
            if (!rdy_b) seen_low = 1;
            else if (seen_low) rose = 1;
         end
         chk("empty_rose", 32'(rose), 32'd1);
         chk("empty_not_early", 32'(done_b), 32'd0);
         @(negedge clk);
         chk("empty_done", 32'(done_b), 32'd1);
         chk("empty_busy", 32'(busy_b), 32'd0);
         chk("empty_error", 32'(err_b), 32'd0);
      end
      chk("b_no_cmd", 32'(vcnt_b - v0), 32'd0);
   endtask

   initial begin
      int n[NW];
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_busy", 32'(busy_a), 32'd0);
      chk("rst_a_done", 32'(done_a), 32'd0);
      chk("rst_a_error", 32'(err_a), 32'd0);
      chk("rst_a_fail", 32'(fail_a), 32'd0);
      chk("rst_a_prst", 32'(prst_a), 32'd0);
      chk("rst_a_valid", 32'(ifa.cmd_valid_o), 32'd0);
      chk("rst_a_dev", 32'(ifa.cmd_dev_o), 32'(DEV));
      chk("rst_b_busy", 32'(busy_b), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      run_a(0, 0, 0, 1'b1, 0);
      run_a(0, 2, 0, 1'b0, 0);
      run_a(0, 0, 4, 1'b0, 0);
      run_a(0, 3, 0, 1'b0, 0);
      run_a(0, 0, 0, 1'b0, 30);
      reset_mid();
      run_a(0, 0, 0, 1'b0, 0);

      rand_ready = 1;
      lat_lo = 1;
      lat_hi = 6;
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < NW; k++) begin
            n[k] = ($urandom_range(0, 5) == 0) ? 4 : $urandom_range(0, 3);
         end
         rise_a = $urandom_range(3, 150);
         run_a(n[0], n[1], n[2], 1'b0, 0);
      end

      run_b(1'b1);
      run_b(1'b0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
